// File: rtl/ysyx_22050243_pipe_pkg.sv
// Shared encodings for the pipeline sequencer.
// Fetch FSM states and the sequential PC increment.
package ysyx_22050243_pipe_pkg;

    typedef enum logic [1:0] {
        F_REQ  = 2'd0,
        F_WAIT = 2'd1,
        F_DROP = 2'd2
    } fetch_state_e;

    localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/ysyx_22050243_sat_cnt.sv
// Saturating up-counter used for the stall/flush performance counters.
// Sticks at all-ones instead of wrapping.
module ysyx_22050243_sat_cnt #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/ysyx_22050243_pipe_ctrl.sv
// Pipeline sequencer: merges stalls, redirects and traps into per-register
// hold/flush controls and runs the instruction-fetch handshake FSM.
module ysyx_22050243_pipe_ctrl
    import ysyx_22050243_pipe_pkg::*;
#(
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PC_WIDTH-1:0]  pc,
    input  logic                 load_use_stall,
    input  logic                 mdu_busy,
    input  logic                 mem_req,
    input  logic                 mem_done,
    input  logic                 ex_redir,
    input  logic [PC_WIDTH-1:0]  ex_redir_pc,
    input  logic                 trap,
    input  logic [PC_WIDTH-1:0]  trap_pc,
    output logic                 if_req_valid,
    input  logic                 if_req_ready,
    input  logic                 if_resp_valid,
    output logic                 if_resp_ready,
    output logic                 pc_we,
    output logic [PC_WIDTH-1:0]  npc,
    output logic                 hold_ifid,
    output logic                 hold_idex,
    output logic                 hold_exmem,
    output logic                 flush_ifid,
    output logic                 flush_idex,
    output logic                 flush_exmem,
    output logic                 flush_memwb,
    output logic [CNT_WIDTH-1:0] cnt_stall,
    output logic [CNT_WIDTH-1:0] cnt_flush
);

    fetch_state_e        state_q, state_d;
    logic [PC_WIDTH-1:0] redir_pc_q, redir_pc_d;

    logic                mem_busy;
    logic                trap_acc;
    logic                br_acc;
    logic                redirect_acc;
    logic [PC_WIDTH-1:0] target;
    logic [PC_WIDTH-1:0] pc_inc;

    always_comb begin
        mem_busy     = mem_req & ~mem_done;
        trap_acc     = trap & ~mem_busy;
        br_acc       = ex_redir & ~mem_busy & ~mdu_busy & ~trap;
        redirect_acc = trap_acc | br_acc;
        target       = trap_acc ? trap_pc : ex_redir_pc;
        pc_inc       = pc + PC_WIDTH'(PC_INC);
    end

    always_comb begin
        hold_ifid     = 1'b0;
        hold_idex     = 1'b0;
        hold_exmem    = 1'b0;
        flush_ifid    = 1'b0;
        flush_idex    = 1'b0;
        flush_exmem   = 1'b0;
        flush_memwb   = 1'b0;
        if_req_valid  = 1'b0;
        if_resp_ready = 1'b0;
        pc_we         = 1'b0;
        npc           = pc_inc;
        state_d       = state_q;
        redir_pc_d    = redir_pc_q;

        if (trap_acc) begin
            flush_ifid  = 1'b1;
            flush_idex  = 1'b1;
            flush_exmem = 1'b1;
        end else if (mem_busy) begin
            hold_ifid   = 1'b1;
            hold_idex   = 1'b1;
            hold_exmem  = 1'b1;
            flush_memwb = 1'b1;
        end else if (mdu_busy) begin
            hold_ifid   = 1'b1;
            hold_idex   = 1'b1;
            flush_exmem = 1'b1;
        end else if (br_acc) begin
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
        end else if (load_use_stall) begin
            hold_ifid  = 1'b1;
            flush_idex = 1'b1;
        end

        unique case (state_q)
            F_REQ: begin
                if_req_valid = ~redirect_acc;
                if (redirect_acc) begin
                    pc_we = 1'b1;
                    npc   = target;
                end else if (if_req_ready) begin
                    state_d = F_WAIT;
                end
            end
            F_WAIT: begin
                if_resp_ready = ~hold_ifid | redirect_acc;
                if (redirect_acc) begin
                    if (if_resp_valid) begin
                        pc_we   = 1'b1;
                        npc     = target;
                        state_d = F_REQ;
                    end else begin
                        redir_pc_d = target;
                        state_d    = F_DROP;
                    end
                end else if (if_resp_valid && if_resp_ready) begin
                    pc_we   = 1'b1;
                    state_d = F_REQ;
                end else if (!hold_ifid) begin
                    flush_ifid = 1'b1;
                end
            end
            F_DROP: begin
                // stale fetch still in flight; a held IF/ID is left untouched
                if_resp_ready = 1'b1;
                if (!hold_ifid) begin
                    flush_ifid = 1'b1;
                end
                if (if_resp_valid) begin
                    pc_we   = 1'b1;
                    npc     = redirect_acc ? target : redir_pc_q;
                    state_d = F_REQ;
                end else if (redirect_acc) begin
                    redir_pc_d = target;
                end
            end
            default: begin
                state_d = F_REQ;
            end
        endcase

        if (!rst_n) begin
            if_req_valid  = 1'b0;
            if_resp_ready = 1'b0;
            pc_we         = 1'b0;
            hold_ifid     = 1'b0;
            hold_idex     = 1'b0;
            hold_exmem    = 1'b0;
            flush_ifid    = 1'b1;
            flush_idex    = 1'b1;
            flush_exmem   = 1'b1;
            flush_memwb   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= F_REQ;
            redir_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            redir_pc_q <= redir_pc_d;
        end
    end

    ysyx_22050243_sat_cnt #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_cnt_stall (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (hold_ifid),
        .count(cnt_stall)
    );

    ysyx_22050243_sat_cnt #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_cnt_flush (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (redirect_acc),
        .count(cnt_flush)
    );

endmodule
